// File: rtl/date_pkg.sv
// Shared types and constants for the calendar stage.
// Define DATE_COUNTER_LEAP_EN to enable Feb 29 in leap years; otherwise February is always 28 days.
package date_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [2:0] wday_t;

  localparam logic [7:0] JAN = 8'h01;
  localparam logic [7:0] FEB = 8'h02;
  localparam logic [7:0] MAR = 8'h03;
  localparam logic [7:0] APR = 8'h04;
  localparam logic [7:0] MAY = 8'h05;
  localparam logic [7:0] JUN = 8'h06;
  localparam logic [7:0] JUL = 8'h07;
  localparam logic [7:0] AUG = 8'h08;
  localparam logic [7:0] SEP = 8'h09;
  localparam logic [7:0] OCT = 8'h10;
  localparam logic [7:0] NOV = 8'h11;
  localparam logic [7:0] DEC = 8'h12;

  localparam logic [7:0] RESET_DAY   = 8'h01;
  localparam logic [7:0] RESET_MONTH = JAN;

  localparam wday_t WDAY_LAST = 3'd6;

`ifdef DATE_COUNTER_LEAP_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  // Two-digit BCD increment; 99 wraps to 00 (caller detects the wrap).
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Combinational month length in BCD for a BCD month/year (year taken as 2000..2099).
module days_in_month
  import date_pkg::*;
(
  input  bcd_t month1,
  input  bcd_t month2,
  input  bcd_t year1,
  input  bcd_t year2,
  output bcd_t len1,
  output bcd_t len2
);

  logic       leap;
  logic [7:0] len;

  // Divisibility by 4 of a two-digit BCD year depends only on tens parity and units.
  always_comb begin
    leap = 1'b0;
    if (year1[0]) leap = (year2 == 4'd2) || (year2 == 4'd6);
    else          leap = (year2 == 4'd0) || (year2 == 4'd4) || (year2 == 4'd8);
    leap = leap && LEAP_EN;
  end

  always_comb begin
    len = 8'h31;
    case ({month1, month2})
      FEB:                len = leap ? 8'h29 : 8'h28;
      APR, JUN, SEP, NOV: len = 8'h30;
      default:            len = 8'h31;
    endcase
  end

  assign len1 = len[7:4];
  assign len2 = len[3:0];

endmodule

// File: rtl/date_counter.sv
// Running BCD date/weekday register: validated load from the setting stage, midnight advance.
// Leap handling follows DATE_COUNTER_LEAP_EN (see date_pkg).
module date_counter
  import date_pkg::*;
#(
  parameter wday_t RESET_WEEKDAY    = 3'd0,
  parameter bcd_t  RESET_YEAR_TENS  = 4'd0,
  parameter bcd_t  RESET_YEAR_UNITS = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       day_tick,
  input  logic [3:0] set_day1,
  input  logic [3:0] set_day2,
  input  logic [3:0] set_month1,
  input  logic [3:0] set_month2,
  input  logic [3:0] set_year1,
  input  logic [3:0] set_year2,
  input  logic [2:0] set_weekday,
  output logic [3:0] day1,
  output logic [3:0] day2,
  output logic [3:0] month1,
  output logic [3:0] month2,
  output logic [3:0] year1,
  output logic [3:0] year2,
  output logic [2:0] weekday,
  output logic       load_err,
  output logic       year_wrap
);

  logic [7:0] day_q, day_d, month_q, month_d, year_q, year_d;
  wday_t      wday_q, wday_d;
  logic       load_err_q, load_err_d, year_wrap_q, year_wrap_d;

  logic       digit_bad, month_bad, day_bad, year_bad, wday_bad;
  logic [7:0] ld_month, ld_year, ld_day, set_day, set_month;
  bcd_t       ld_len1, ld_len2, cur_len1, cur_len2;

  assign set_day   = {set_day1, set_day2};
  assign set_month = {set_month1, set_month2};

  assign digit_bad = (set_day1 > 4'd3) || (set_day2 > 4'd9) ||
                     (set_month1 > 4'd9) || (set_month2 > 4'd9);
  assign month_bad = digit_bad || (set_month == 8'h00) || (set_month > DEC);
  assign ld_month  = month_bad ? JAN : set_month;
  assign ld_year   = {(set_year1 > 4'd9) ? 4'd0 : set_year1,
                      (set_year2 > 4'd9) ? 4'd0 : set_year2};
  assign year_bad  = (set_year1 > 4'd9) || (set_year2 > 4'd9);
  assign wday_bad  = (set_weekday == 3'd7);

  // Load-side length uses the already-corrected month/year so day checks see final values.
  days_in_month u_len_load (
    .month1 (ld_month[7:4]),
    .month2 (ld_month[3:0]),
    .year1  (ld_year[7:4]),
    .year2  (ld_year[3:0]),
    .len1   (ld_len1),
    .len2   (ld_len2)
  );

  days_in_month u_len_cur (
    .month1 (month_q[7:4]),
    .month2 (month_q[3:0]),
    .year1  (year_q[7:4]),
    .year2  (year_q[3:0]),
    .len1   (cur_len1),
    .len2   (cur_len2)
  );

  assign day_bad = digit_bad || (set_day == 8'h00) || (set_day > {ld_len1, ld_len2});
  assign ld_day  = day_bad ? RESET_DAY : set_day;

  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    wday_d      = wday_q;
    load_err_d  = 1'b0;
    year_wrap_d = 1'b0;
    if (load) begin
      day_d      = ld_day;
      month_d    = ld_month;
      year_d     = ld_year;
      wday_d     = wday_bad ? 3'd0 : set_weekday;
      load_err_d = month_bad || day_bad || year_bad || wday_bad;
    end else if (day_tick) begin
      wday_d = (wday_q == WDAY_LAST) ? 3'd0 : wday_q + 3'd1;
      if (day_q < {cur_len1, cur_len2}) begin
        day_d = bcd2_inc(day_q);
      end else begin
        day_d = RESET_DAY;
        if (month_q == DEC) begin
          month_d     = JAN;
          year_d      = bcd2_inc(year_q);
          year_wrap_d = (year_q == 8'h99);
        end else begin
          month_d = bcd2_inc(month_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_q       <= RESET_DAY;
      month_q     <= RESET_MONTH;
      year_q      <= {RESET_YEAR_TENS, RESET_YEAR_UNITS};
      wday_q      <= RESET_WEEKDAY;
      load_err_q  <= 1'b0;
      year_wrap_q <= 1'b0;
    end else begin
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      wday_q      <= wday_d;
      load_err_q  <= load_err_d;
      year_wrap_q <= year_wrap_d;
    end
  end

  assign day1      = day_q[7:4];
  assign day2      = day_q[3:0];
  assign month1    = month_q[7:4];
  assign month2    = month_q[3:0];
  assign year1     = year_q[7:4];
  assign year2     = year_q[3:0];
  assign weekday   = wday_q;
  assign load_err  = load_err_q;
  assign year_wrap = year_wrap_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed check of date_counter: loads, validation, month/year rollover, async reset.
module tb_date_counter;

  logic       clk = 1'b0, rst = 1'b1, load = 1'b0, day_tick = 1'b0;
  logic [3:0] set_day1 = '0, set_day2 = '0, set_month1 = '0, set_month2 = '0;
  logic [3:0] set_year1 = '0, set_year2 = '0;
  logic [2:0] set_weekday = '0;
  logic [3:0] day1, day2, month1, month2, year1, year2;
  logic [2:0] weekday;
  logic       load_err, year_wrap;

  int n_vec = 0;
  int n_err = 0;

  date_counter #(
    .RESET_WEEKDAY    (3'd0),
    .RESET_YEAR_TENS  (4'd0),
    .RESET_YEAR_UNITS (4'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .day_tick    (day_tick),
    .set_day1    (set_day1),
    .set_day2    (set_day2),
    .set_month1  (set_month1),
    .set_month2  (set_month2),
    .set_year1   (set_year1),
    .set_year2   (set_year2),
    .set_weekday (set_weekday),
    .day1        (day1),
    .day2        (day2),
    .month1      (month1),
    .month2      (month2),
    .year1       (year1),
    .year2       (year2),
    .weekday     (weekday),
    .load_err    (load_err),
    .year_wrap   (year_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed as DD MM YY 0W for readable hex expectations.
  function automatic logic [31:0] date_now();
    return {day1, day2, month1, month2, year1, year2, 5'b0, weekday};
  endfunction

  task automatic set_in(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y,
                        input logic [2:0] w);
    {set_day1, set_day2}     = d;
    {set_month1, set_month2} = m;
    {set_year1, set_year2}   = y;
    set_weekday              = w;
  endtask

  task automatic step(input logic ld, input logic tk);
    load     = ld;
    day_tick = tk;
    @(posedge clk);
    #1;
    load     = 1'b0;
    day_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_date", date_now(), 32'h01010000);
    check("reset_err", 32'(load_err), 32'd0);
    check("reset_wrap", 32'(year_wrap), 32'd0);
    rst = 1'b0;

    set_in(8'h28, 8'h02, 8'h24, 3'd3);
    step(1'b1, 1'b0);
    check("load_28_02_24", date_now(), 32'h28022403);
    check("load_28_02_24_err", 32'(load_err), 32'd0);
    step(1'b0, 1'b1);
`ifdef DATE_COUNTER_LEAP_EN
    check("tick_feb28_leap", date_now(), 32'h29022404);
    step(1'b0, 1'b1);
    check("tick_feb29_leap", date_now(), 32'h01032405);
`else
    check("tick_feb28_noleap", date_now(), 32'h01032404);
    step(1'b0, 1'b1);
    check("tick_mar01", date_now(), 32'h02032405);
`endif

    set_in(8'h28, 8'h02, 8'h23, 3'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("tick_feb28_2023", date_now(), 32'h01032301);

    set_in(8'h29, 8'h02, 8'h24, 3'd2);
    step(1'b1, 1'b0);
`ifdef DATE_COUNTER_LEAP_EN
    check("load_feb29_leap", date_now(), 32'h29022402);
    check("load_feb29_leap_err", 32'(load_err), 32'd0);
`else
    check("load_feb29_fixed", date_now(), 32'h01022402);
    check("load_feb29_err", 32'(load_err), 32'd1);
`endif
    step(1'b0, 1'b0);
    check("load_err_one_cycle", 32'(load_err), 32'd0);

    set_in(8'h31, 8'h12, 8'h99, 3'd6);
    step(1'b1, 1'b0);
    check("load_31_12_99", date_now(), 32'h31129906);
    step(1'b0, 1'b1);
    check("tick_year_wrap_date", date_now(), 32'h01010000);
    check("tick_year_wrap_pulse", 32'(year_wrap), 32'd1);
    step(1'b0, 1'b0);
    check("year_wrap_one_cycle", 32'(year_wrap), 32'd0);
    check("idle_holds_date", date_now(), 32'h01010000);

    set_in(8'h31, 8'h04, 8'h25, 3'd1);
    step(1'b1, 1'b0);
    check("load_31_04_fixed", date_now(), 32'h01042501);
    check("load_31_04_err", 32'(load_err), 32'd1);
    set_in(8'h15, 8'h13, 8'h25, 3'd1);
    step(1'b1, 1'b0);
    check("load_month13_fixed", date_now(), 32'h15012501);
    check("load_month13_err", 32'(load_err), 32'd1);
    set_in(8'h30, 8'h06, 8'h25, 3'd1);
    step(1'b1, 1'b0);
    check("load_30_06", date_now(), 32'h30062501);
    check("load_30_06_err", 32'(load_err), 32'd0);

    set_in(8'h10, 8'h05, 8'h25, 3'd2);
    step(1'b1, 1'b1);
    check("load_and_tick", date_now(), 32'h10052502);
    step(1'b0, 1'b1);
    check("tick_after_load", date_now(), 32'h11052503);

    set_in(8'h09, 8'h09, 8'h25, 3'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("tick_day_09_10", date_now(), 32'h10092501);
    set_in(8'h19, 8'h09, 8'h25, 3'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("tick_day_19_20", date_now(), 32'h20092501);
    set_in(8'h30, 8'h09, 8'h25, 3'd5);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("tick_30_09", date_now(), 32'h01102506);
    step(1'b0, 1'b1);
    check("tick_weekday_wrap", date_now(), 32'h02102500);

    set_in(8'h05, 8'h05, 8'h25, 3'd7);
    step(1'b1, 1'b0);
    check("load_wday7_fixed", date_now(), 32'h05052500);
    check("load_wday7_err", 32'(load_err), 32'd1);

    set_in(8'h31, 8'h12, 8'h09, 3'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("tick_year_09_10", date_now(), 32'h01011001);
    check("tick_year_09_10_wrap", 32'(year_wrap), 32'd0);

    step(1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_date", date_now(), 32'h01010000);
    rst = 1'b0;
    step(1'b0, 1'b1);
    check("tick_from_reset", date_now(), 32'h02010001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
- Calendar stage directly downstream of the date-setting stage.
- Holds the running date (day, month, two-digit year, weekday) as BCD digits.
- Loads the user-set values when setting is committed.
- Advances one day on each midnight tick from the time-keeping stage, with month-length and leap-year handling; outputs drive the display mux.

Parameters:
- RESET_WEEKDAY, 0, weekday value after reset (0..6).
- RESET_YEAR_TENS, 0, year tens digit after reset (0..9).
- RESET_YEAR_UNITS, 0, year units digit after reset (0..9).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle pulse: commit the set_* values.
- day_tick  input  1  one-cycle pulse: midnight rollover from time stage.
- set_day1  input  4  BCD day tens (0..3).
- set_day2  input  4  BCD day units.
- set_month1  input  4  BCD month tens.
- set_month2  input  4  BCD month units.
- set_year1  input  4  BCD year tens.
- set_year2  input  4  BCD year units.
- set_weekday  input  3  weekday 0..6.
- day1, day2, month1, month2, year1, year2  output  4 each  current date, BCD; suffix 1 = tens, 2 = units.
- weekday  output  3  current weekday 0..6.
- load_err  output  1  one-cycle pulse: last load was corrected.
- year_wrap  output  1  one-cycle pulse: year rolled 99 -> 00.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - Date 01/01/RESET_YEAR_TENS RESET_YEAR_UNITS; weekday = RESET_WEEKDAY.
  - load_err = 0, year_wrap = 0.
- Latency: outputs reflect a load or tick on the clock edge sampling it (1 cycle). Pulse outputs are high exactly one cycle.
- Priority: rst > load > day_tick. A tick coinciding with a load is discarded, not deferred.
- All registers are plain BCD; no binary conversion is stored.
- Month length:
  - 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
  - February: 29 in leap years, else 28.
- Leap year (two-digit year treated as 2000..2099):
  - Tens digit even: leap when units is 0, 4 or 8.
  - Tens digit odd: leap when units is 2 or 6.
- Load validation, using the loaded month/year:
  - Any digit > 9, or day1 > 3: month forced to 01 and day forced to 01.
  - Month 00 or > 12: month forced to 01.
  - Day 00 or day > month length: day forced to 01.
  - Year digits > 9: that digit forced to 0.
  - set_weekday = 7: forced to 0.
  - Any correction pulses load_err on the same edge the corrected values appear.
- Tick handling, one edge:
  - weekday advances 6 -> 0 wrap.
  - If day < month length: day increments with BCD carry (09 -> 10, 19 -> 20, 29 -> 30).
  - Else day -> 01 and month increments (09 -> 10).
  - If month was 12: month -> 01 and year increments with BCD carry (09 -> 10, 99 -> 00). 99 -> 00 also pulses year_wrap.
- Ticks while no load has occurred since reset advance from the reset date.
- Reset asserted mid-operation: all state returns to reset values immediately. Pulses in flight are lost.
- No internal FSM beyond the counter chain. Day, month and year are a cascaded enable chain driven by the end-of-month and end-of-year compares.

Optional Feature:
- Macro: DATE_COUNTER_LEAP_EN.
- Defined: leap-year rule above applies (Feb 29 valid).
- Undefined: February is always 28 days. A loaded day 29 in February is corrected to 01 with load_err.

Decomposition:
- Package date_pkg holds:
  - BCD digit typedef (4 bits); weekday typedef (3 bits).
  - Month constants JAN..DEC.
  - Reset-date constants.
  - Weekday wrap constant 6.
- Sub-module: combinational days_in_month, inputs (month1, month2, year1, year2), output BCD tens/units of month length. Shared by load validation and tick logic.

Test Plan:
- Reset -> 01/01/00, weekday 0; load 28/02/24 wd 3, tick -> 29/02/24 wd 4; tick -> 01/03/24 wd 5.
- Load 28/02/23, tick -> 01/03/23 (non-leap); with macro undefined, load 29/02/24 -> 01/02/24 and load_err pulse.
- Load 31/12/99 wd 6, tick -> 01/01/00, weekday 0, year_wrap one cycle high.
- Load 31/04/25 -> 01/04/25 with load_err; load 15/13/25 -> 15/01/25 with load_err; load 30/06/25 -> no load_err.
- load and day_tick same cycle with 10/05/25 -> 10/05/25 exactly (tick dropped); next tick alone -> 11/05/25.
- Tick chain 09 -> 10, 19 -> 20, 30/09 -> 01/10; assert rst mid-sequence -> 01/01/00 asynchronously, before the next clock edge.
